// File: rtl/mdf_pkg.sv
// mdf_pkg: shared constants and FSM states for the MDF divider and its frequency meter
package mdf_pkg;
  localparam int MDF_CODE_W = 4;
  localparam int MDF_HMAX = 16;
  typedef enum logic {ESPERA, MIDE} estado_t;
endpackage

// File: rtl/frec_medidor_detector_flanco.sv
// detector_flanco: input stage and both-edge strobe; FRECMED_SYNC_EN adds a 2-flop synchronizer
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic entrada,
  output logic flanco
);
  logic s, s_prev;
`ifdef FRECMED_SYNC_EN
  logic meta;
  // two-flop synchronizer feeding the edge-detect register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta <= 1'b0;
      s <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      meta <= entrada;
      s <= meta;
      s_prev <= s;
    end
`else
  // single input register for synchronous stimulus
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s <= entrada;
      s_prev <= s;
    end
`endif
  assign flanco = s != s_prev;
endmodule

// File: rtl/frec_medidor.sv
// frec_medidor: measures the half-period of a square wave and decodes the MDF code (sync stage: FRECMED_SYNC_EN)
module frec_medidor
  import mdf_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int N_CONF = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  entrada,
  output logic [CNT_W-1:0]      q,
  output logic [MDF_CODE_W-1:0] codigo,
  output logic                  valido,
  output logic                  error
);
  localparam int CONF_W = $clog2(N_CONF + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HMAX = CNT_W'(MDF_HMAX);
  localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(N_CONF);
  logic flanco, en_rango, err_n;
  logic [CNT_W-1:0] cnt, dif;
  logic [CONF_W-1:0] conf, conf_n;
  estado_t estado;
  detector_flanco u_det (
    .clk(clk),
    .rst(rst),
    .entrada(entrada),
    .flanco(flanco)
  );
  // judge the half just completed against the previous one
  always_comb begin
    en_rango = cnt != '0 && cnt <= HMAX;
    dif = cnt > q ? cnt - q : q - cnt;
    err_n = !en_rango || (conf != '0 && dif > CNT_W'(1));
    conf_n = (en_rango && cnt == q) ? (conf == CONF_MAX ? conf : conf + CONF_W'(1)) : CONF_W'(1);
  end
  // half-period counter: restarts at 1 on every edge, saturates when the wave stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= flanco ? CNT_W'(1) : (cnt == CNT_MAX ? cnt : cnt + CNT_W'(1));
  // measurement FSM with registered results; an edge takes priority over the timeout
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      estado <= ESPERA;
      q <= '0;
      codigo <= '0;
      conf <= '0;
      error <= 1'b0;
      valido <= 1'b0;
    end else if (estado == ESPERA) begin
      if (flanco) estado <= MIDE;
    end else if (flanco) begin
      q <= cnt;
      if (en_rango) codigo <= cnt[MDF_CODE_W-1:0] - MDF_CODE_W'(1);
      conf <= conf_n;
      error <= err_n;
      valido <= conf_n == CONF_MAX && !err_n;
    end else if (cnt == CNT_MAX) begin
      q <= CNT_MAX;
      conf <= '0;
      error <= 1'b1;
      valido <= 1'b0;
      estado <= ESPERA;
    end
endmodule

// File: tb/tb_frec_medidor.sv
// tb_frec_medidor: table vectors, corner sequences and random halves checked against a half-period model
module tb_frec_medidor;
  logic clk = 1'b0, rst = 1'b1, entrada = 1'b0;
  logic [15:0] q;
  logic [3:0] codigo;
  logic valido, error;
  int checks = 0, failures = 0;
  int m_q = 0, m_cod = 0, m_nh = 0, m_conf = 0, since = 0;
  bit m_err = 0, m_val = 0, started = 0;
  typedef struct {
    int h;
    int q;
    int cod;
    bit err;
    bit val;
  } vec_t;
  vec_t tabla[8];

  frec_medidor dut (
    .clk(clk),
    .rst(rst),
    .entrada(entrada),
    .q(q),
    .codigo(codigo),
    .valido(valido),
    .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    chk({name, ".q"}, q, m_q);
    chk({name, ".codigo"}, codigo, m_cod);
    chk({name, ".error"}, error, m_err);
    chk({name, ".valido"}, valido, m_val);
  endtask

  task automatic model_reset();
    m_q = 0; m_cod = 0; m_nh = 0; m_conf = 0;
    m_err = 0; m_val = 0; started = 0; since = 0;
  endtask

  task automatic model_half(input int h);
    bit ok;
    int d;
    ok = h <= 16;
    d = h > m_q ? h - m_q : m_q - h;
    m_err = !ok || (m_nh > 0 && d > 1);
    m_conf = (ok && m_nh > 0 && h == m_q) ? m_conf + 1 : 1;
    m_nh++;
    m_q = h;
    if (ok) m_cod = h - 1;
    m_val = m_conf >= 2 && !m_err;
  endtask

  task automatic tog();
    entrada = ~entrada;
    if (started) model_half(since);
    started = 1;
    since = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      since++;
      if (started && since == 65536) begin
        m_q = 65535; m_err = 1; m_val = 0;
        m_nh = 0; m_conf = 0; started = 0;
      end
    end
  endtask

  initial begin
    int last;
    int h;
    tabla = '{'{16, 16, 15, 1'b0, 1'b1}, '{20, 20, 15, 1'b1, 1'b0},
              '{1, 1, 0, 1'b0, 1'b1},    '{5, 5, 4, 1'b0, 1'b1},
              '{2, 2, 1, 1'b0, 1'b1},    '{9, 9, 8, 1'b0, 1'b1},
              '{17, 17, 8, 1'b1, 1'b0},  '{11, 11, 10, 1'b0, 1'b1}};
    model_reset();
    tick(3);
    rst = 1'b0;
    chk("reset.q", q, 0);
    chk("reset.codigo", codigo, 0);
    chk("reset.error", error, 0);
    chk("reset.valido", valido, 0);
    tick(2);
    since = 0;
    for (int i = 0; i < 8; i++) begin
      repeat (6) begin
        tog();
        tick(tabla[i].h);
      end
      if (tabla[i].h < 3) tick(4);
      chk($sformatf("tab%0d.q", i), q, tabla[i].q);
      chk($sformatf("tab%0d.codigo", i), codigo, tabla[i].cod);
      chk($sformatf("tab%0d.error", i), error, tabla[i].err);
      chk($sformatf("tab%0d.valido", i), valido, tabla[i].val);
    end
    tog(); tick(3);
    tog(); tick(3);
    chk("h11to3.first.valido", valido, 0);
    chk("h11to3.first.q", q, 3);
    tog(); tick(3);
    chk("h11to3.second.valido", valido, 1);
    chk("h11to3.second.codigo", codigo, 2);
    for (int i = 0; i < 8; i++) begin
      tog();
      tick(i % 2 ? 9 : 5);
      if (i > 0) begin
        chk($sformatf("asym%0d.error", i), error, 1);
        chk($sformatf("asym%0d.valido", i), valido, 0);
        chk($sformatf("asym%0d.q", i), q, i % 2 ? 5 : 9);
      end
    end
    last = 8;
    for (int i = 0; i < 40; i++) begin
      h = ($urandom_range(0, 1) == 0) ? last : int'($urandom_range(3, 20));
      tog();
      tick(h);
      chk_model($sformatf("rand%0d", i));
      last = h;
    end
    repeat (4) begin
      tog();
      tick(8);
    end
    chk("prereset.valido", valido, 1);
    tog();
    tick(3);
    #2 rst = 1'b1;
    #1;
    chk("midrst.q", q, 0);
    chk("midrst.codigo", codigo, 0);
    chk("midrst.error", error, 0);
    chk("midrst.valido", valido, 0);
    model_reset();
    entrada = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    since = 0;
    for (int i = 1; i <= 3; i++) begin
      tog();
      tick(8);
      chk_model($sformatf("afterrst%0d", i));
      chk($sformatf("afterrst%0d.valido", i), valido, i == 3);
    end
    repeat (4) begin
      tog();
      tick(16);
    end
    chk_model("prestuck");
    tog();
    tick(65000);
    chk_model("stuck.early");
    tick(600);
    chk_model("stuck.timeout");
    chk("stuck.q", q, 16'hFFFF);
    tog();
    tick(8);
    chk_model("resume.start");
    tog();
    tick(8);
    chk_model("resume.half");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
